uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter that sits inside system, directly upstream of the UartTx pin.
- Accepts bytes from system logic through a write-strobe interface and queues them in an internal FIFO.
- Serialises each byte at uart_baud_rate, derived from clk_freq, so internal logic never stalls for a byte time.

Parameters:
- clk_freq, 50000000: system clock frequency in Hz.
- uart_baud_rate, 9600: serial bit rate in baud.
- fifo_depth, 16: FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to enqueue.
- tx_wr  input  1  write strobe; one byte per cycle while high.
- tx_full  output  1  FIFO holds fifo_depth entries.
- tx_empty  output  1  FIFO holds 0 entries.
- tx_busy  output  1  a frame is in progress, or the FIFO is non-empty.
- tx_ovf  output  1  one-cycle pulse when a write is dropped.
- UartTx  output  1  serial line; idle high.

Behaviour:
- Bit period: DIV = clk_freq / uart_baud_rate, integer division, truncated. DIV < 2 is illegal (simulation-time $error). The baud counter is wide enough for DIV-1.
- Reset (rst high at a clock edge):
  - FIFO pointers and count cleared; state = IDLE; baud counter = 0; bit index = 0.
  - Outputs: UartTx=1, tx_empty=1, tx_full=0, tx_busy=0, tx_ovf=0.
  - Reset mid-frame aborts the frame; UartTx is high from the next edge. Queued data is discarded.
- FIFO writes:
  - A write is accepted when tx_wr=1 and tx_full=0, both evaluated at the same edge from registered values.
  - When tx_wr=1 and tx_full=1, the byte is dropped and tx_ovf=1 for exactly the next cycle. This applies even if a pop occurs on that same edge; no write-through on full.
  - Simultaneous accepted write and pop leaves the count unchanged.
  - Pointers wrap modulo fifo_depth. Count ranges 0..fifo_depth. tx_full and tx_empty are registered and reflect the count after each edge.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: UartTx=1. If FIFO non-empty, pop the head into shift register, go to START, clear the baud counter. UartTx goes low on the cycle after the pop edge. Latency from an accepted write into an empty FIFO while IDLE to the UartTx falling edge: 2 cycles.
  - START: UartTx=0 for DIV cycles, then DATA with bit index 0.
  - DATA: UartTx = shift[0] for DIV cycles, then shift right. After bit index 7, go to STOP. Bits go out LSB first.
  - STOP: UartTx=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle); otherwise go to IDLE.
  - Frame length: exactly 10*DIV cycles.
- tx_busy = (state != IDLE) or (tx_empty = 0). Combinational from registered state.
- UartTx is driven from a register (glitch-free).

Test Plan:
- clk_freq=1000, uart_baud_rate=100 (DIV=10); reset, then write 0x55 once -> UartTx falls 2 cycles after the write. Line shows 0,1,0,1,0,1,0,1,0,1, each held 10 cycles. Afterwards tx_busy=0 and tx_empty=1.
- Same params; write 0xA3 then 0x0F on consecutive cycles -> two frames. Bit sequences 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1. The second start bit immediately follows the first stop bit (frame edges 100 cycles apart).
- fifo_depth=4; write 6 bytes on consecutive cycles while IDLE -> the first byte is popped into the frame. tx_full=1 after the 5th write, the 6th write is dropped with a 1-cycle tx_ovf pulse, and 5 frames are transmitted in order.
- Hold the FIFO full and assert tx_wr on the same edge the STOP->START pop occurs -> write dropped, tx_ovf pulses, count goes fifo_depth -> fifo_depth-1.
- Assert rst for 1 cycle during DATA bit 3 of a frame, with 2 bytes queued -> UartTx=1 next cycle, tx_empty=1, tx_busy=0. No further frames; a new write afterwards transmits normally.
- Default params (DIV=5208); write 0x00 -> UartTx low for 9*5208=46872 cycles, then high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a write-strobe FIFO feeding a start/data/stop
// serialiser whose bit period is clk_freq / uart_baud_rate clock cycles.
module uart_tx_fifo #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 9600,
  parameter int fifo_depth     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_ovf,
  output logic       UartTx
);

  localparam int DIV        = clk_freq / uart_baud_rate;
  localparam int CNT_W      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W      = (fifo_depth > 2) ? $clog2(fifo_depth) : 1;
  localparam int FIFO_CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]      BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(fifo_depth);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: clk_freq / uart_baud_rate must be at least 2");
  end

  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: fifo_depth must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift_reg;
  logic [7:0]            mem [fifo_depth];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FIFO_CNT_W-1:0] count;
  logic [FIFO_CNT_W-1:0] count_next;
  logic                  wr_accept;
  logic                  pop;
  logic                  bit_done;
  logic                  line_next;

  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign wr_accept = tx_wr && !tx_full;
  assign tx_busy   = (state != IDLE) || !tx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!tx_empty) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (bit_done) state_next = tx_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // The line value is registered, so it trails the state by one cycle; every
  // bit slot is still exactly DIV cycles wide.
  always_comb begin
    pop       = 1'b0;
    line_next = 1'b1;
    case (state)
      IDLE:    pop = !tx_empty;
      START:   line_next = 1'b0;
      DATA:    line_next = shift_reg[0];
      STOP:    pop = bit_done && !tx_empty;
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      UartTx    <= 1'b1;
    end else begin
      UartTx <= line_next;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        baud_cnt  <= '0;
        bit_idx   <= 3'd0;
      end else if (state != IDLE) begin
        if (bit_done) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_comb begin
    count_next = count;
    case ({wr_accept, pop})
      2'b10:   count_next = count + FIFO_CNT_W'(1);
      2'b01:   count_next = count - FIFO_CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Full/empty are registered from the post-edge count; a write while full is
  // dropped even if a pop frees a slot on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      tx_ovf   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      tx_full  <= (count_next == FIFO_FULL);
      tx_empty <= (count_next == '0);
      tx_ovf   <= tx_wr && tx_full;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed frame scenarios,
// randomized traffic against a time-based reference model, and a default-rate run.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;
  localparam int DEF_DIV  = 50000000 / 9600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_full, tx_empty, tx_busy, tx_ovf, UartTx;

  logic       d_rst = 1'b1;
  logic       d_wr = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_full, d_empty, d_busy, d_ovf, d_line;

  uart_tx_fifo #(.clk_freq(CLK_FREQ), .uart_baud_rate(BAUD), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .tx_empty(tx_empty), .tx_busy(tx_busy), .tx_ovf(tx_ovf), .UartTx(UartTx)
  );

  uart_tx_fifo dut_def (
    .clk(clk), .rst(d_rst), .tx_data(d_data), .tx_wr(d_wr), .tx_full(d_full),
    .tx_empty(d_empty), .tx_busy(d_busy), .tx_ovf(d_ovf), .UartTx(d_line)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  bit def_done = 1'b0;

  // Reference model: a byte queue plus the number of cycles since the current
  // frame's head was popped (-1 when no frame is running).
  logic [7:0] mq[$];
  logic [7:0] m_done[$];
  logic [7:0] cur_byte = 8'h00;
  int         fpos = -1;
  logic       m_line = 1'b1;
  logic       m_ovf = 1'b0;

  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_bits = '0;
  logic [7:0] rx_q[$];
  int         fall_times[$];

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] d;
    logic       line;
    logic       full;
    logic       empty;
    logic       busy;
    logic       ovf;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [7:0] d);
    int  pre_size;
    int  bitn;
    bit  do_pop;
    if (r) begin
      mq.delete();
      fpos   = -1;
      m_line = 1'b1;
      m_ovf  = 1'b0;
      return;
    end
    pre_size = mq.size();
    if (fpos < 0) begin
      m_line = 1'b1;
    end else begin
      bitn = fpos / DIV;
      if (bitn == 0) m_line = 1'b0;
      else if (bitn <= 8) m_line = cur_byte[bitn-1];
      else m_line = 1'b1;
    end
    do_pop = (pre_size > 0) && (fpos < 0 || fpos == FRAME - 1);
    if (fpos == FRAME - 1) begin
      m_done.push_back(cur_byte);
      fpos = -1;
    end else if (fpos >= 0) begin
      fpos++;
    end
    if (do_pop) begin
      cur_byte = mq.pop_front();
      fpos = 0;
    end
    m_ovf = w && (pre_size == DEPTH);
    if (w && pre_size < DEPTH) mq.push_back(d);
  endtask

  function automatic bit model_pop_next();
    return (mq.size() > 0) && (fpos < 0 || fpos == FRAME - 1);
  endfunction

  // Line monitor: decodes frames from the serial pin by mid-bit sampling.
  task automatic mon_step(input logic r);
    if (r) begin
      mon_active = 1'b0;
      return;
    end
    if (!mon_active) begin
      if (UartTx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        fall_times.push_back(cycle);
      end
    end else begin
      mon_cnt++;
    end
    if (mon_active) begin
      if (mon_cnt % DIV == DIV / 2) mon_bits[mon_cnt / DIV] = UartTx;
      if (mon_cnt == FRAME - 1) begin
        checkOutput("mon_start_bit", 32'(mon_bits[0]), 32'd0);
        checkOutput("mon_stop_bit", 32'(mon_bits[9]), 32'd1);
        rx_q.push_back(mon_bits[8:1]);
        mon_active = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d);
    rst = r;
    tx_wr = w;
    tx_data = d;
    @(posedge clk);
    model_edge(r, w, d);
    @(negedge clk);
    cycle++;
    mon_step(r);
    rst = 1'b0;
    tx_wr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, ".line"}, 32'(UartTx), 32'(m_line));
    checkOutput({tag, ".full"}, 32'(tx_full), 32'(mq.size() == DEPTH));
    checkOutput({tag, ".empty"}, 32'(tx_empty), 32'(mq.size() == 0));
    checkOutput({tag, ".busy"}, 32'(tx_busy), 32'(fpos >= 0 || mq.size() > 0));
    checkOutput({tag, ".ovf"}, 32'(tx_ovf), 32'(m_ovf));
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d, input string tag);
    applyStimulus(r, w, d);
    check_model(tag);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((tx_busy || UartTx == 1'b0) && n < 7 * FRAME) begin
      step(1'b0, 1'b0, 8'h00, tag);
      n++;
    end
    checkOutput({tag, ".drain_in_time"}, 32'(n < 7 * FRAME), 32'd1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp_q[$]);
    checkOutput({tag, ".frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checkOutput($sformatf("%s.byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic clear_capture();
    rx_q.delete();
    fall_times.delete();
    m_done.delete();
  endtask

  initial begin
    vec_t       vecs[9];
    logic [7:0] exp_q[$];
    int         n;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].d);
      checkOutput($sformatf("vec%0d.line", i), 32'(UartTx), 32'(vecs[i].line));
      checkOutput($sformatf("vec%0d.full", i), 32'(tx_full), 32'(vecs[i].full));
      checkOutput($sformatf("vec%0d.empty", i), 32'(tx_empty), 32'(vecs[i].empty));
      checkOutput($sformatf("vec%0d.busy", i), 32'(tx_busy), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d.ovf", i), 32'(tx_ovf), 32'(vecs[i].ovf));
    end

    // FIFO full while the first frame ends: a write on the pop edge is dropped.
    n = 0;
    while (!model_pop_next() && n < 2 * FRAME) begin
      step(1'b0, 1'b0, 8'h00, "full_wait");
      n++;
    end
    checkOutput("full_at_boundary", 32'(tx_full), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hEE);
    checkOutput("boundary.ovf", 32'(tx_ovf), 32'd1);
    checkOutput("boundary.full", 32'(tx_full), 32'd0);
    checkOutput("boundary.empty", 32'(tx_empty), 32'd0);
    drain("fill");
    exp_q = {8'h55, 8'hA3, 8'h0F, 8'h81, 8'h3C};
    check_rx("fill", exp_q);
    checkOutput("fill.back_to_back", 32'(fall_times.size() > 1 ? fall_times[1] - fall_times[0] : 0), 32'(FRAME));

    // Single byte: two-cycle latency from write to start bit.
    clear_capture();
    step(1'b1, 1'b0, 8'h00, "single_rst");
    step(1'b0, 1'b1, 8'h55, "single_wr");
    n = 0;
    while (UartTx && n < 10) begin
      step(1'b0, 1'b0, 8'h00, "single_lat");
      n++;
    end
    checkOutput("single.latency", 32'(n), 32'd2);
    drain("single");
    exp_q = {8'h55};
    check_rx("single", exp_q);
    checkOutput("single.busy_after", 32'(tx_busy), 32'd0);
    checkOutput("single.empty_after", 32'(tx_empty), 32'd1);

    // Two consecutive writes produce abutting frames.
    clear_capture();
    step(1'b0, 1'b1, 8'hA3, "pair_wr0");
    step(1'b0, 1'b1, 8'h0F, "pair_wr1");
    drain("pair");
    exp_q = {8'hA3, 8'h0F};
    check_rx("pair", exp_q);
    checkOutput("pair.edge_gap", 32'(fall_times.size() > 1 ? fall_times[1] - fall_times[0] : 0), 32'(FRAME));

    // Reset in the middle of data bit 3 with two bytes still queued.
    clear_capture();
    step(1'b0, 1'b1, 8'h5A, "abort_wr0");
    step(1'b0, 1'b1, 8'hC3, "abort_wr1");
    step(1'b0, 1'b1, 8'h96, "abort_wr2");
    n = 0;
    while (fpos != 4 * DIV + 5 && n < 3 * FRAME) begin
      step(1'b0, 1'b0, 8'h00, "abort_wait");
      n++;
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("abort.line", 32'(UartTx), 32'd1);
    checkOutput("abort.empty", 32'(tx_empty), 32'd1);
    checkOutput("abort.busy", 32'(tx_busy), 32'd0);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 8'h00, "abort_quiet");
    checkOutput("abort.no_frames", 32'(rx_q.size()), 32'd0);
    step(1'b0, 1'b1, 8'h7E, "abort_new");
    drain("abort_new");
    exp_q = {8'h7E};
    check_rx("abort_new", exp_q);

    // Random traffic with occasional resets, checked cycle by cycle.
    clear_capture();
    for (int i = 0; i < 2500; i++) begin
      step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)), "rand");
    end
    drain("rand");
    check_rx("rand", m_done);

    n = 0;
    while (!def_done && n < 60000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("default.finished", 32'(def_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Default baud rate: one 0x00 frame keeps the line low for nine bit times.
  initial begin
    int t;
    int low;
    @(posedge clk);
    @(negedge clk);
    d_rst = 1'b0;
    d_wr = 1'b1;
    d_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    d_wr = 1'b0;
    t = 0;
    while (d_line && t < 10) begin
      @(negedge clk);
      t++;
    end
    checkOutput("default.latency", 32'(t), 32'd2);
    low = 0;
    while (!d_line && low < 60000) begin
      @(negedge clk);
      low++;
    end
    checkOutput("default.low_cycles", 32'(low), 32'(9 * DEF_DIV));
    checkOutput("default.line_high", 32'(d_line), 32'd1);
    checkOutput("default.busy_in_stop", 32'(d_busy), 32'd1);
    checkOutput("default.empty", 32'(d_empty), 32'd1);
    checkOutput("default.full", 32'(d_full), 32'd0);
    checkOutput("default.ovf", 32'(d_ovf), 32'd0);
    def_done = 1'b1;
  end

endmodule
